llc_model: RTL and testbench
============================

LLC_MODEL -- requirements
Module: llc_model

Interface
REQ-001 Parameter NUM_CH, default 2, number of requesting cache channels (ch0 = L1I, ch1 = L1D).
REQ-002 Parameter LINE_BYTES, default 64, cache-line size; LINE_BITS = 8*LINE_BYTES.
REQ-003 Parameter DEPTH_LINES, default 64 (4 KB), lines of backing storage, power of two.
REQ-004 Parameter LATENCY, default 4, cycles from request accept to response valid; legal range 1..255.
REQ-005 clk_in  input  1  single clock; all state updates on rising edge.
REQ-006 rst_in  input  1  reset, asynchronous and active-high.
REQ-007 req_valid_in  input  NUM_CH  per-channel request valid.
REQ-008 req_ready_out  output  NUM_CH  per-channel request ready; at most one bit high per cycle.
REQ-009 req_addr_in  input  NUM_CH x 64  request byte address.
REQ-010 req_we_in  input  NUM_CH  1 = line write, 0 = line read.
REQ-011 req_value_in  input  NUM_CH x LINE_BITS  write data.
REQ-012 resp_valid_out  output  NUM_CH  response valid, only on the owning channel.
REQ-013 resp_ready_in  input  NUM_CH  response accept.
REQ-014 resp_addr_out  output  64  line-aligned address of the response.
REQ-015 resp_value_out  output  LINE_BITS  read data, or the written data for a write ack.
REQ-016 resp_we_out  output  1  echo of the request's write-enable.
REQ-017 preload_valid_in / preload_addr_in (64) / preload_value_in (LINE_BITS)  input  bench/boot line write port.
REQ-018 busy_out  output  1  high whenever the state is not IDLE.

Function
REQ-019 States: IDLE, WAIT, RESP. Exactly one outstanding transaction in total.
REQ-020 IDLE: the round-robin arbiter picks one channel with req_valid_in set and drives only that channel's req_ready_out high; the handshake completes when valid && ready at an edge.
REQ-021 Round-robin pointer: starts at ch0 after reset and advances to (granted+1) mod NUM_CH only on an accepted handshake.
REQ-022 req_ready_out is 0 in WAIT and RESP, and in any cycle where preload_valid_in = 1.
REQ-023 Line index = addr[log2(LINE_BYTES) +: log2(DEPTH_LINES)]; higher bits are ignored, so addresses wrap modulo the storage size. Low offset bits are ignored; resp_addr_out has those offset bits zeroed.
REQ-024 On accept:
  - a write updates storage at that edge;
  - a read captures the line at that edge;
  - addr, we and channel are latched; the counter loads LATENCY-1 and the state moves to WAIT.
REQ-025 WAIT: the counter decrements each cycle; at 0 the state moves to RESP. resp_valid_out rises exactly LATENCY cycles after the accept edge.
REQ-026 RESP: resp_valid_out[ch] and the response fields hold stable until resp_ready_in[ch] is high at an edge; then the state moves to IDLE. A new request can be accepted no earlier than the next cycle.
REQ-027 Preload writes storage at any edge in any state. It does not alter data already captured for an in-flight read.
REQ-028 Storage contents are not initialised; a read of a never-written line returns X.

Reset
REQ-029 rst_in asserted forces, immediately:
  - state IDLE, counter 0, RR pointer 0;
  - all req_ready_out and resp_valid_out 0, busy_out 0;
  - resp_addr_out, resp_value_out and resp_we_out all 0.
REQ-030 Reset mid-transaction discards it with no response. Storage contents are retained, including a write already accepted.

Structure
REQ-031 llc_pkg holds the state enum (llc_state_t), the request struct (addr, we, value) and localparams OFFSET_W and INDEX_W.
REQ-032 Sub-module rr_arbiter #(N) computes a one-hot grant from the request vector and pointer; it is combinational, with the pointer register kept in llc_model.

Verification
REQ-033 Preload 0x0 with line 0xA5..A5, then ch0 reads 0x0 accepted at edge T -> resp_valid_out[0] at edge T+4, value A5..A5, resp_addr 0x0.
REQ-034 ch0 and ch1 hold req_valid continuously for 4 reads -> grants alternate ch0, ch1, ch0, ch1; never two ready bits high together.
REQ-035 ch1 writes 0x1234_5678 to 0x40, then ch0 reads 0x1040 (DEPTH 64) -> returns the written line (wrap), resp_addr 0x1040.
REQ-036 resp_ready_in held 0 for 10 cycles -> response fields stable; a pending request on the other channel stays unaccepted until 1 cycle after the response handshake.
REQ-037 rst_in pulsed in WAIT -> outputs zero at once; no response later; a new read after reset completes with LATENCY 4.
REQ-038 LATENCY=1 build: read accepted at edge T -> resp_valid at T+1; preload of the same line at T+1 does not change that response.

Source files
------------

// File: rtl/llc_pkg.sv
// Shared types and helpers for the last-level-cache timing model.
package llc_pkg;

  localparam int unsigned DEF_LINE_BYTES  = 64;
  localparam int unsigned DEF_DEPTH_LINES = 64;
  localparam int unsigned MAX_LINE_BITS   = 8 * DEF_LINE_BYTES;
  localparam int unsigned OFFSET_W        = $clog2(DEF_LINE_BYTES);
  localparam int unsigned INDEX_W         = $clog2(DEF_DEPTH_LINES);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } llc_state_t;

  typedef struct packed {
    logic [63:0]              addr;
    logic                     we;
    logic [MAX_LINE_BITS-1:0] value;
  } llc_req_t;

  function automatic logic [63:0] line_align(input logic [63:0] addr, input int unsigned off_w);
    return (addr >> off_w) << off_w;
  endfunction

endpackage

// File: rtl/llc_model_if.sv
// Request/response/preload bundle between cache channels and the LLC model.
interface llc_model_if #(
  parameter int unsigned NUM_CH    = 2,
  parameter int unsigned LINE_BITS = 512
);
  logic [NUM_CH-1:0]                req_valid_in;
  logic [NUM_CH-1:0]                req_ready_out;
  logic [NUM_CH-1:0][63:0]          req_addr_in;
  logic [NUM_CH-1:0]                req_we_in;
  logic [NUM_CH-1:0][LINE_BITS-1:0] req_value_in;
  logic [NUM_CH-1:0]                resp_valid_out;
  logic [NUM_CH-1:0]                resp_ready_in;
  logic [63:0]                      resp_addr_out;
  logic [LINE_BITS-1:0]             resp_value_out;
  logic                             resp_we_out;
  logic                             preload_valid_in;
  logic [63:0]                      preload_addr_in;
  logic [LINE_BITS-1:0]             preload_value_in;
  logic                             busy_out;

  modport master (
    output req_valid_in, req_addr_in, req_we_in, req_value_in, resp_ready_in,
           preload_valid_in, preload_addr_in, preload_value_in,
    input  req_ready_out, resp_valid_out, resp_addr_out, resp_value_out, resp_we_out, busy_out
  );

  modport slave (
    input  req_valid_in, req_addr_in, req_we_in, req_value_in, resp_ready_in,
           preload_valid_in, preload_addr_in, preload_value_in,
    output req_ready_out, resp_valid_out, resp_addr_out, resp_value_out, resp_we_out, busy_out
  );
endinterface

// File: rtl/llc_model_rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or after ptr wins.
module rr_arbiter #(
  parameter int unsigned N     = 2,
  parameter int unsigned PTR_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N-1:0]     grant
);

  logic [PTR_W-1:0] idx_s;
  logic             found_s;

  // scan channels starting at the pointer, grant the first one asserting req
  always_comb begin
    grant   = '0;
    found_s = 1'b0;
    idx_s   = '0;
    for (int i = 0; i < N; i++) begin
      idx_s        = PTR_W'((32'(ptr) + 32'(i)) % N);
      grant[idx_s] = req[idx_s] & ~found_s;
      found_s      = found_s | req[idx_s];
    end
  end

endmodule

// File: rtl/llc_model.sv
// Single-outstanding LLC model: round-robin request arbitration, fixed
// access latency, held response, and a side preload port into line storage.
module llc_model #(
  parameter int unsigned NUM_CH      = 2,
  parameter int unsigned LINE_BYTES  = 64,
  parameter int unsigned DEPTH_LINES = 64,
  parameter int unsigned LATENCY     = 4
) (
  input logic        clk_in,
  input logic        rst_in,
  llc_model_if.slave bus
);
  import llc_pkg::*;

  localparam int unsigned LINE_BITS = 8 * LINE_BYTES;
  localparam int unsigned OFF_W     = $clog2(LINE_BYTES);
  localparam int unsigned IDX_W     = $clog2(DEPTH_LINES);
  localparam int unsigned PTR_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  llc_state_t           state_r, state_s;
  logic [7:0]           cnt_r;
  logic [PTR_W-1:0]     ptr_r, ch_r, gnt_idx_s, ptr_next_s;
  logic [NUM_CH-1:0]    gnt_s, ready_s, resp_valid_r;
  llc_req_t             req_r;
  logic [LINE_BITS-1:0] mem [DEPTH_LINES];
  logic                 accept_s, resp_done_s, wait_done_s, unused_s;
  logic [63:0]          req_addr_s;
  logic                 req_we_s;
  logic [LINE_BITS-1:0] req_value_s;
  logic [IDX_W-1:0]     req_idx_s, pre_idx_s;

  rr_arbiter #(.N(NUM_CH), .PTR_W(PTR_W)) u_arb (
    .req   (bus.req_valid_in),
    .ptr   (ptr_r),
    .grant (gnt_s)
  );

  // ready is suppressed during reset so a held valid cannot leak a grant
  assign ready_s     = (state_r == ST_IDLE && !bus.preload_valid_in && !rst_in) ? gnt_s : '0;
  assign accept_s    = |(ready_s & bus.req_valid_in);
  assign wait_done_s = (state_r == ST_WAIT) && (cnt_r == 8'd0);
  assign resp_done_s = (state_r == ST_RESP) && bus.resp_ready_in[ch_r];
  assign ptr_next_s  = (gnt_idx_s == PTR_W'(NUM_CH - 1)) ? '0 : gnt_idx_s + PTR_W'(1);
  assign req_idx_s   = req_addr_s[OFF_W +: IDX_W];
  assign pre_idx_s   = bus.preload_addr_in[OFF_W +: IDX_W];
  assign unused_s    = ^{bus.preload_addr_in[63:OFF_W+IDX_W], bus.preload_addr_in[OFF_W-1:0]};

  // one-hot grant selects the winning channel's request fields
  always_comb begin
    gnt_idx_s   = '0;
    req_addr_s  = 64'd0;
    req_we_s    = 1'b0;
    req_value_s = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      gnt_idx_s   = gnt_idx_s   | (gnt_s[i] ? PTR_W'(i) : PTR_W'(0));
      req_addr_s  = req_addr_s  | (gnt_s[i] ? bus.req_addr_in[i] : 64'd0);
      req_we_s    = req_we_s    | (gnt_s[i] & bus.req_we_in[i]);
      req_value_s = req_value_s | (gnt_s[i] ? bus.req_value_in[i] : {LINE_BITS{1'b0}});
    end
  end

  // next-state logic
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: state_s = accept_s    ? ST_WAIT : ST_IDLE;
      ST_WAIT: state_s = wait_done_s ? ST_RESP : ST_WAIT;
      ST_RESP: state_s = resp_done_s ? ST_IDLE : ST_RESP;
      default: state_s = ST_IDLE;
    endcase
  end

  // state register
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) state_r <= ST_IDLE;
    else        state_r <= state_s;
  end

  // transaction latch, latency counter, RR pointer and response valid
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      cnt_r        <= 8'd0;
      ptr_r        <= '0;
      ch_r         <= '0;
      req_r        <= '0;
      resp_valid_r <= '0;
    end else begin
      if (accept_s) begin
        cnt_r       <= 8'(LATENCY - 1);
        ptr_r       <= ptr_next_s;
        ch_r        <= gnt_idx_s;
        req_r.addr  <= line_align(req_addr_s, OFF_W);
        req_r.we    <= req_we_s;
        req_r.value <= MAX_LINE_BITS'(req_we_s ? req_value_s : mem[req_idx_s]);
      end else if (state_r == ST_WAIT && cnt_r != 8'd0) begin
        cnt_r <= cnt_r - 8'd1;
      end
      if (wait_done_s)      resp_valid_r <= NUM_CH'(1) << ch_r;
      else if (resp_done_s) resp_valid_r <= '0;
    end
  end

  // storage has no reset; preload and accepted writes never coincide
  always_ff @(posedge clk_in) begin
    if (bus.preload_valid_in)       mem[pre_idx_s] <= bus.preload_value_in;
    else if (accept_s && req_we_s)  mem[req_idx_s] <= req_value_s;
  end

  assign bus.req_ready_out  = ready_s;
  assign bus.resp_valid_out = resp_valid_r;
  assign bus.resp_addr_out  = req_r.addr;
  assign bus.resp_we_out    = req_r.we;
  assign bus.resp_value_out = req_r.value[LINE_BITS-1:0];
  assign bus.busy_out       = (state_r != ST_IDLE);

endmodule

// File: tb/tb_llc_model.sv
// Bench for llc_model: directed vector table, corner sequences and a
// randomized phase checked against a plain line-array reference model.
module tb_llc_model;

  localparam int LB   = 512;
  localparam int LAT  = 4;
  localparam logic [LB-1:0] A5 = {64{8'hA5}};

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  llc_model_if #(.NUM_CH(2), .LINE_BITS(LB)) bus  ();
  llc_model_if #(.NUM_CH(2), .LINE_BITS(LB)) bus1 ();

  llc_model #(.NUM_CH(2), .LINE_BYTES(64), .DEPTH_LINES(64), .LATENCY(LAT)) dut (
    .clk_in(clk), .rst_in(rst), .bus(bus));
  llc_model #(.NUM_CH(2), .LINE_BYTES(64), .DEPTH_LINES(64), .LATENCY(1)) dut1 (
    .clk_in(clk), .rst_in(rst), .bus(bus1));

  typedef struct {
    int            ch;
    logic          we;
    logic [63:0]   addr;
    logic [LB-1:0] val;
    int            hold;
    logic [LB-1:0] exp_val;
    logic [63:0]   exp_addr;
  } vec_t;

  int            checks = 0;
  int            passes = 0;
  int            onehot_viol = 0;
  logic [LB-1:0] model [64];
  vec_t          vecs [5];

  always @(negedge clk) begin
    if ($countones(bus.req_ready_out) > 1 || $countones(bus1.req_ready_out) > 1) onehot_viol++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  task automatic check(input string nm, input logic [LB-1:0] act, input logic [LB-1:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h required %0h", nm, act, exp);
  endtask

  function automatic int line_of(input logic [63:0] a);
    return int'((a / 64) % 64);
  endfunction

  function automatic logic [LB-1:0] rand_line();
    logic [LB-1:0] v;
    for (int j = 0; j < 16; j++) v[j*32 +: 32] = $urandom;
    return v;
  endfunction

  // called at posedge+1; returns at posedge+1
  task automatic preload(input logic [63:0] a, input logic [LB-1:0] v);
    bus.preload_valid_in = 1'b1; bus.preload_addr_in = a; bus.preload_value_in = v;
    @(posedge clk); #1;
    bus.preload_valid_in = 1'b0;
    model[line_of(a)] = v;
  endtask

  // one full transaction on the main DUT; called and returns at posedge+1
  task automatic do_txn(input int ch, input logic we, input logic [63:0] a, input logic [LB-1:0] v,
                        input int hold, input logic [LB-1:0] exp_val, input logic [63:0] exp_addr,
                        input string nm);
    bit ok;
    int lat;
    bus.req_valid_in[ch] = 1'b1; bus.req_we_in[ch] = we;
    bus.req_addr_in[ch]  = a;    bus.req_value_in[ch] = v;
    ok = 1'b0;
    for (int k = 0; k < 50 && !ok; k++) begin
      @(negedge clk);
      if (bus.req_ready_out[ch]) ok = 1'b1;
      else begin @(posedge clk); #1; end
    end
    check({nm, " grant"}, ok, 1'b1);
    @(posedge clk); #1;
    bus.req_valid_in[ch] = 1'b0;
    lat = 0; ok = 1'b0;
    while (!ok && lat < 300) begin
      @(negedge clk);
      if (lat == 0) check({nm, " busy"}, bus.busy_out, 1'b1);
      if (bus.resp_valid_out[ch]) ok = 1'b1;
      else lat++;
    end
    check({nm, " latency"}, lat, LAT);
    check({nm, " value"}, bus.resp_value_out, exp_val);
    check({nm, " addr"}, bus.resp_addr_out, exp_addr);
    check({nm, " we"}, bus.resp_we_out, we);
    check({nm, " other valid"}, bus.resp_valid_out[1-ch], 1'b0);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check({nm, " hold"}, {bus.resp_valid_out[ch], bus.resp_addr_out, bus.resp_value_out},
            {1'b1, exp_addr, exp_val});
    end
    bus.resp_ready_in[ch] = 1'b1;
    @(posedge clk); #1;
    bus.resp_ready_in[ch] = 1'b0;
    if (we) model[line_of(a)] = v;
  endtask

  initial begin
    logic [LB-1:0] wv, pv1, pv2;
    logic [63:0]   ra;
    int            gch, cnt, bad;
    bit            ok;

    bus.req_valid_in = '0; bus.req_addr_in = '0; bus.req_we_in = '0; bus.req_value_in = '0;
    bus.resp_ready_in = '0; bus.preload_valid_in = 1'b0; bus.preload_addr_in = 64'd0;
    bus.preload_value_in = '0;
    bus1.req_valid_in = '0; bus1.req_addr_in = '0; bus1.req_we_in = '0; bus1.req_value_in = '0;
    bus1.resp_ready_in = '0; bus1.preload_valid_in = 1'b0; bus1.preload_addr_in = 64'd0;
    bus1.preload_value_in = '0;

    // reset state, with requests held to show ready stays low
    bus.req_valid_in = 2'b11;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset ready", bus.req_ready_out, 2'b00);
    check("reset resp_valid", bus.resp_valid_out, 2'b00);
    check("reset busy", bus.busy_out, 1'b0);
    check("reset fields", {bus.resp_addr_out, bus.resp_we_out, bus.resp_value_out}, '0);
    @(posedge clk); #1;
    rst = 1'b0; bus.req_valid_in = 2'b00;

    // both channels request continuously: grants alternate from ch0
    preload(64'h0, A5);
    bus.req_addr_in = '0; bus.req_we_in = 2'b00; bus.req_valid_in = 2'b11;
    for (int g = 0; g < 4; g++) begin
      ok = 1'b0;
      for (int k = 0; k < 50 && !ok; k++) begin
        @(negedge clk);
        if (|bus.req_ready_out) ok = 1'b1;
        else begin @(posedge clk); #1; end
      end
      gch = bus.req_ready_out[1] ? 1 : 0;
      check("rr grant", gch, g % 2);
      @(posedge clk); #1;
      ok = 1'b0;
      for (int k = 0; k < 50 && !ok; k++) begin
        @(negedge clk);
        if (bus.resp_valid_out[gch]) ok = 1'b1;
      end
      check("rr value", bus.resp_value_out, A5);
      bus.resp_ready_in[gch] = 1'b1;
      @(posedge clk); #1;
      bus.resp_ready_in[gch] = 1'b0;
    end
    bus.req_valid_in = 2'b00;

    // directed vector table: write ack, wrap read, offset/high-bit masking
    wv = '0; wv[31:0] = 32'h1234_5678;
    pv1 = {16{32'hC0DE_0002}};
    vecs[0] = '{ch: 1, we: 1'b1, addr: 64'h40, val: wv, hold: 0, exp_val: wv, exp_addr: 64'h40};
    vecs[1] = '{ch: 0, we: 1'b0, addr: 64'h1040, val: '0, hold: 0, exp_val: wv, exp_addr: 64'h1040};
    vecs[2] = '{ch: 0, we: 1'b1, addr: 64'h85, val: pv1, hold: 2, exp_val: pv1, exp_addr: 64'h80};
    vecs[3] = '{ch: 1, we: 1'b0, addr: 64'h1_0000_00BF, val: '0, hold: 3, exp_val: pv1,
                exp_addr: 64'h1_0000_0080};
    vecs[4] = '{ch: 0, we: 1'b0, addr: 64'h0, val: '0, hold: 0, exp_val: A5, exp_addr: 64'h0};
    for (int i = 0; i < 5; i++)
      do_txn(vecs[i].ch, vecs[i].we, vecs[i].addr, vecs[i].val, vecs[i].hold,
             vecs[i].exp_val, vecs[i].exp_addr, $sformatf("vec%0d", i));

    // response held 10 cycles while ch1 waits; ch1 granted right after handshake
    bus.req_valid_in[0] = 1'b1; bus.req_we_in[0] = 1'b0; bus.req_addr_in[0] = 64'h40;
    ok = 1'b0;
    for (int k = 0; k < 50 && !ok; k++) begin
      @(negedge clk);
      if (bus.req_ready_out[0]) ok = 1'b1;
      else begin @(posedge clk); #1; end
    end
    @(posedge clk); #1;
    bus.req_valid_in = 2'b10; bus.req_we_in[1] = 1'b0; bus.req_addr_in[1] = 64'h0;
    cnt = 0;
    while (!bus.resp_valid_out[0] && cnt < 50) begin @(negedge clk); cnt++; end
    for (int h = 0; h < 10; h++) begin
      @(negedge clk);
      check("stall fields", {bus.resp_valid_out, bus.resp_addr_out, bus.resp_value_out},
            {2'b01, 64'h40, wv});
      check("stall ch1 ready", bus.req_ready_out[1], 1'b0);
    end
    bus.resp_ready_in[0] = 1'b1;
    @(posedge clk); #1;
    bus.resp_ready_in[0] = 1'b0;
    @(negedge clk);
    check("post-handshake ch1 ready", bus.req_ready_out[1], 1'b1);
    @(posedge clk); #1;
    bus.req_valid_in[1] = 1'b0;
    cnt = 0;
    while (!bus.resp_valid_out[1] && cnt < 50) begin @(negedge clk); cnt++; end
    check("ch1 after stall value", bus.resp_value_out, A5);
    bus.resp_ready_in[1] = 1'b1;
    @(posedge clk); #1;
    bus.resp_ready_in[1] = 1'b0;

    // reset during WAIT of an accepted write: no response, write retained
    wv = {16{32'h5555_0005}};
    bus.req_valid_in[0] = 1'b1; bus.req_we_in[0] = 1'b1; bus.req_addr_in[0] = 64'h140;
    bus.req_value_in[0] = wv;
    ok = 1'b0;
    for (int k = 0; k < 50 && !ok; k++) begin
      @(negedge clk);
      if (bus.req_ready_out[0]) ok = 1'b1;
      else begin @(posedge clk); #1; end
    end
    @(posedge clk); #1;
    bus.req_valid_in[0] = 1'b0;
    model[5] = wv;
    @(negedge clk);
    check("pre-reset busy", bus.busy_out, 1'b1);
    #1 rst = 1'b1;
    #1;
    check("mid reset outputs", {bus.busy_out, bus.resp_valid_out, bus.req_ready_out,
          bus.resp_addr_out, bus.resp_we_out, bus.resp_value_out}, '0);
    @(posedge clk); #1;
    rst = 1'b0;
    bad = 0;
    for (int k = 0; k < LAT + 6; k++) begin
      @(negedge clk);
      if (bus.resp_valid_out != 2'b00 || bus.busy_out) bad++;
    end
    check("no response after reset", bad, 0);
    @(posedge clk); #1;
    do_txn(0, 1'b0, 64'h140, '0, 0, wv, 64'h140, "after reset read");

    // a preload in the same cycle blocks ready
    bus.req_valid_in[0] = 1'b1; bus.req_we_in[0] = 1'b0; bus.req_addr_in[0] = 64'h1C0;
    pv1 = rand_line();
    bus.preload_valid_in = 1'b1; bus.preload_addr_in = 64'h1C0; bus.preload_value_in = pv1;
    @(negedge clk);
    check("ready during preload", bus.req_ready_out, 2'b00);
    bus.req_valid_in[0] = 1'b0;
    @(posedge clk); #1;
    bus.preload_valid_in = 1'b0;
    model[7] = pv1;
    do_txn(1, 1'b0, 64'h1C0, '0, 0, pv1, 64'h1C0, "read preloaded");

    // randomized traffic over lines 0..7 with random high/offset bits
    for (int l = 0; l < 8; l++) preload(64'(l * 64), rand_line());
    for (int n = 0; n < 40; n++) begin
      ra = {$urandom, $urandom};
      ra[11:6] = 6'($urandom_range(0, 7));
      if ($urandom_range(0, 5) == 0) begin
        preload(ra, rand_line());
      end else begin
        logic          rwe;
        logic [LB-1:0] rv;
        int            rch;
        rwe = 1'($urandom_range(0, 1));
        rv  = rand_line();
        rch = $urandom_range(0, 1);
        do_txn(rch, rwe, ra, rv, $urandom_range(0, 3), rwe ? rv : model[line_of(ra)],
               ra - (ra % 64), $sformatf("rand%0d", n));
      end
    end

    // LATENCY=1 build: response one edge after accept, unaffected by a preload then
    pv1 = {16{32'h1111_0003}};
    pv2 = {16{32'h2222_0003}};
    bus1.preload_valid_in = 1'b1; bus1.preload_addr_in = 64'hC0; bus1.preload_value_in = pv1;
    @(posedge clk); #1;
    bus1.preload_valid_in = 1'b0;
    bus1.req_valid_in[1] = 1'b1; bus1.req_we_in[1] = 1'b0; bus1.req_addr_in[1] = 64'hC0;
    ok = 1'b0;
    for (int k = 0; k < 50 && !ok; k++) begin
      @(negedge clk);
      if (bus1.req_ready_out[1]) ok = 1'b1;
      else begin @(posedge clk); #1; end
    end
    check("lat1 grant", ok, 1'b1);
    @(posedge clk); #1;
    bus1.req_valid_in[1] = 1'b0;
    bus1.preload_valid_in = 1'b1; bus1.preload_value_in = pv2;
    @(negedge clk);
    check("lat1 early valid", bus1.resp_valid_out, 2'b00);
    @(posedge clk); #1;
    bus1.preload_valid_in = 1'b0;
    @(negedge clk);
    check("lat1 valid", bus1.resp_valid_out, 2'b10);
    check("lat1 value", bus1.resp_value_out, pv1);
    check("lat1 addr", bus1.resp_addr_out, 64'hC0);
    bus1.resp_ready_in[1] = 1'b1;
    @(posedge clk); #1;
    bus1.resp_ready_in[1] = 1'b0;
    bus1.req_valid_in[0] = 1'b1; bus1.req_we_in[0] = 1'b0; bus1.req_addr_in[0] = 64'hC0;
    cnt = 0;
    while (!bus1.resp_valid_out[0] && cnt < 50) begin
      @(negedge clk); cnt++;
      if (bus1.req_ready_out[0]) begin @(posedge clk); #1; bus1.req_valid_in[0] = 1'b0; end
    end
    check("lat1 reread value", bus1.resp_value_out, pv2);
    bus1.req_valid_in[0] = 1'b0;
    bus1.resp_ready_in[0] = 1'b1;
    @(posedge clk); #1;
    bus1.resp_ready_in[0] = 1'b0;

    check("ready onehot", onehot_viol, 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
